// File: rtl/sram_arbiter.sv
// Two-requester (CPU read/write, DMA read-only) arbiter driving an async SRAM
// through IDLE/SETUP/ACCESS/DONE. Define SRAM_ARB_ROUND_ROBIN_EN for fair arbitration.
module sram_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iCpuReq,
  input  logic              iCpuWe,
  input  logic [ADDR_W-1:0] iCpuAddr,
  input  logic [DATA_W-1:0] iCpuData,
  output logic [DATA_W-1:0] oCpuData,
  output logic              oCpuAck,
  input  logic              iDmaReq,
  input  logic [ADDR_W-1:0] iDmaAddr,
  output logic [DATA_W-1:0] oDmaData,
  output logic              oDmaAck,
  output logic [ADDR_W-1:0] oSramAddr,
  output logic [DATA_W-1:0] oSramData,
  input  logic [DATA_W-1:0] iSramData,
  output logic              oSramDataOe,
  output logic              oSramCe_n,
  output logic              oSramOe_n,
  output logic              oSramWe_n,
  output logic              oBusy
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t              r_state, w_next;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_cpu_data;
  logic [DATA_W-1:0]   r_dma_data;
  logic                r_we;
  logic                r_gnt_dma;
  logic                w_any_req;
  logic                w_gnt_dma;
  logic                w_last_access;

  assign w_any_req     = iCpuReq | iDmaReq;
  assign w_last_access = (r_state == S_ACCESS) && (r_cnt == 4'd0);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // r_last_dma: 1 when DMA owned the most recent grant
  logic r_last_dma;

  assign w_gnt_dma = iDmaReq & (~iCpuReq | ~r_last_dma);

  always_ff @(posedge Clock) begin
    if (Reset)
      r_last_dma <= 1'b0;
    else if (r_state == S_IDLE && w_any_req)
      r_last_dma <= w_gnt_dma;
  end
`else
  assign w_gnt_dma = iDmaReq & ~iCpuReq;
`endif

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (r_cnt == 4'd0) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Datapath: request latch, wait counter, read capture
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cpu_data <= '0;
      r_dma_data <= '0;
      r_we       <= 1'b0;
      r_gnt_dma  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_addr    <= w_gnt_dma ? iDmaAddr : iCpuAddr;
        r_we      <= ~w_gnt_dma & iCpuWe;
        r_gnt_dma <= w_gnt_dma;
        if (!w_gnt_dma) r_wdata <= iCpuData;
      end
      if (r_state == S_SETUP)
        r_cnt <= CNT_INIT;
      else if (r_state == S_ACCESS && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (w_last_access && !r_we) begin
        if (r_gnt_dma) r_dma_data <= iSramData;
        else           r_cpu_data <= iSramData;
      end
    end
  end

  // Output logic; DONE keeps Ce_n/DataOe asserted to give writes hold time
  always_comb begin
    oSramCe_n   = 1'b1;
    oSramOe_n   = 1'b1;
    oSramWe_n   = 1'b1;
    oSramDataOe = 1'b0;
    oCpuAck     = 1'b0;
    oDmaAck     = 1'b0;
    case (r_state)
      S_SETUP: begin
        oSramCe_n   = 1'b0;
        oSramOe_n   = r_we;
        oSramDataOe = r_we;
      end
      S_ACCESS: begin
        oSramCe_n   = 1'b0;
        oSramOe_n   = r_we;
        oSramWe_n   = ~r_we;
        oSramDataOe = r_we;
      end
      S_DONE: begin
        oSramCe_n   = 1'b0;
        oSramDataOe = r_we;
        oCpuAck     = ~r_gnt_dma;
        oDmaAck     = r_gnt_dma;
      end
      default: ;
    endcase
  end

  assign oBusy     = (r_state != S_IDLE);
  assign oSramAddr = r_addr;
  assign oSramData = r_wdata;
  assign oCpuData  = r_cpu_data;
  assign oDmaData  = r_dma_data;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: reset, vector table, random traffic
// against a memory/arbitration model, contention and mid-access reset.
module tb_sram_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int W  = 2;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          iCpuReq, iCpuWe, iDmaReq;
  logic [AW-1:0] iCpuAddr, iDmaAddr;
  logic [DW-1:0] iCpuData, iSramData;
  logic [DW-1:0] oCpuData, oDmaData, oSramData;
  logic [AW-1:0] oSramAddr;
  logic          oCpuAck, oDmaAck, oSramDataOe, oSramCe_n, oSramOe_n, oSramWe_n, oBusy;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .Clock(Clock), .Reset(Reset),
    .iCpuReq(iCpuReq), .iCpuWe(iCpuWe), .iCpuAddr(iCpuAddr), .iCpuData(iCpuData),
    .oCpuData(oCpuData), .oCpuAck(oCpuAck),
    .iDmaReq(iDmaReq), .iDmaAddr(iDmaAddr), .oDmaData(oDmaData), .oDmaAck(oDmaAck),
    .oSramAddr(oSramAddr), .oSramData(oSramData), .iSramData(iSramData),
    .oSramDataOe(oSramDataOe), .oSramCe_n(oSramCe_n), .oSramOe_n(oSramOe_n),
    .oSramWe_n(oSramWe_n), .oBusy(oBusy)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference state: SRAM contents, expected requester data, last grant owner
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] exp_cpu = '0;
  logic [DW-1:0] exp_dma = '0;
  bit            last_dma = 1'b0;

  typedef struct {
    bit            dma;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [6:0] strobes();
    return {oBusy, oSramCe_n, oSramOe_n, oSramWe_n, oSramDataOe, oCpuAck, oDmaAck};
  endfunction

  localparam logic [6:0] IDLE_STROBES = 7'b0111000;

  // One transaction; request is dropped right after the sampling edge.
  task automatic txn(input bit dma, input bit we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, output logic [DW-1:0] got);
    logic [DW-1:0] rd, pc, pd;
    logic [6:0]    e;
    if (!mem.exists(addr)) mem[addr] = DW'($urandom);
    rd = mem[addr];
    pc = exp_cpu;
    pd = exp_dma;
    iSramData = we ? ~rd : rd;
    if (dma) begin
      iDmaReq = 1'b1; iDmaAddr = addr;
    end else begin
      iCpuReq = 1'b1; iCpuWe = we; iCpuAddr = addr; iCpuData = wd;
    end
    tick;
    iCpuReq = 1'b0; iDmaReq = 1'b0;
    iCpuAddr = AW'($urandom); iDmaAddr = AW'($urandom); iCpuData = DW'($urandom);
    last_dma = dma;
    if (we) mem[addr] = wd;
    else if (dma) exp_dma = rd;
    else exp_cpu = rd;
    for (int k = 1; k <= W + 2; k++) begin
      e = {1'b1, 1'b0, ~(~we && k <= W + 1), ~(we && k >= 2 && k <= W + 1),
           we, ~dma && k == W + 2, dma && k == W + 2};
      chk($sformatf("strobes_k%0d", k), 32'(strobes()), 32'(e));
      if (k == 1) begin
        chk("data_held_cpu", 32'(oCpuData), 32'(pc));
        chk("data_held_dma", 32'(oDmaData), 32'(pd));
      end
      if (k < W + 2) tick;
    end
    chk("sram_addr", 32'(oSramAddr), 32'(addr));
    if (we) chk("sram_wdata", 32'(oSramData), 32'(wd));
    chk("cpu_data_ack", 32'(oCpuData), 32'(exp_cpu));
    chk("dma_data_ack", 32'(oDmaData), 32'(exp_dma));
    got = dma ? oDmaData : oCpuData;
    tick;
    chk("idle_after", 32'(strobes()), 32'(IDLE_STROBES));
    chk("addr_stable", 32'(oSramAddr), 32'(addr));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] got;
    bit            wdma[3];
    int            wcyc[3];
    int            nack, both, c, n_acks_rst;
    bit            win;
    logic [AW-1:0] ra;

    Reset = 1'b1; iCpuReq = 1'b1; iCpuWe = 1'b1; iDmaReq = 1'b1;
    iCpuAddr = '1; iDmaAddr = '1; iCpuData = '1; iSramData = '1;
    repeat (3) tick;
    chk("reset_strobes", 32'(strobes()), 32'(IDLE_STROBES));
    chk("reset_addr", 32'(oSramAddr), 0);
    chk("reset_wdata", 32'(oSramData), 0);
    chk("reset_cpu_data", 32'(oCpuData), 0);
    chk("reset_dma_data", 32'(oDmaData), 0);
    iCpuReq = 1'b0; iDmaReq = 1'b0; iCpuWe = 1'b0;
    Reset = 1'b0;
    tick;

    vt[0] = '{1'b0, 1'b1, 18'h00123, 16'hBEEF, 16'h0000};
    vt[1] = '{1'b0, 1'b0, 18'h00123, 16'h0000, 16'hBEEF};
    vt[2] = '{1'b1, 1'b0, 18'h00123, 16'h0000, 16'hBEEF};
    vt[3] = '{1'b0, 1'b1, 18'h3FFFF, 16'hFFFF, 16'h0000};
    vt[4] = '{1'b0, 1'b1, 18'h00000, 16'h1234, 16'h0000};
    vt[5] = '{1'b1, 1'b0, 18'h3FFFF, 16'h0000, 16'hFFFF};
    vt[6] = '{1'b0, 1'b0, 18'h00000, 16'h0000, 16'h1234};
    vt[7] = '{1'b0, 1'b0, 18'h3FFFF, 16'h0000, 16'hFFFF};
    foreach (vt[i]) begin
      txn(vt[i].dma, vt[i].we, vt[i].addr, vt[i].wd, got);
      if (!vt[i].we) chk($sformatf("vec%0d_rdata", i), 32'(got), 32'(vt[i].exp));
    end

    for (int i = 0; i < 24; i++) begin
      bit d, w;
      d  = 1'($urandom);
      w  = d ? 1'b0 : 1'($urandom);
      ra = AW'($urandom_range(16, 23));
      txn(d, w, ra, DW'($urandom), got);
    end

    // Sole DMA request: immediate grant, leaves the pointer on DMA
    txn(1'b1, 1'b0, 18'h00040, 16'h0, got);

    // Both requesters held high continuously
    iCpuReq = 1'b1; iCpuWe = 1'b0; iCpuAddr = 18'h00055;
    iDmaReq = 1'b1; iDmaAddr = 18'h00066; iSramData = 16'hA5A5;
    nack = 0; both = 0; c = 0;
    while (nack < 3 && c < 40) begin
      tick;
      c++;
      if (oCpuAck && oDmaAck) both++;
      if (oCpuAck || oDmaAck) begin
        wdma[nack] = oDmaAck;
        wcyc[nack] = c;
        nack++;
      end
    end
    iCpuReq = 1'b0; iDmaReq = 1'b0;
    chk("ack_exclusive", both, 0);
    chk("grant_count", nack, 3);
    chk("first_latency", wcyc[0], W + 2);
    for (int i = 0; i < 3; i++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      win = ~last_dma;
`else
      win = 1'b0;
`endif
      last_dma = win;
      if (win) exp_dma = 16'hA5A5;
      else     exp_cpu = 16'hA5A5;
      if (i < nack) chk($sformatf("grant%0d_dma", i), 32'(wdma[i]), 32'(win));
      if (i > 0 && i < nack) chk($sformatf("spacing%0d", i), wcyc[i] - wcyc[i-1], W + 3);
    end
    c = 0;
    while (oBusy && c < 10) begin tick; c++; end
    chk("contention_drain", 32'(oBusy), 0);
    chk("contention_cpu_data", 32'(oCpuData), 32'(exp_cpu));
    chk("contention_dma_data", 32'(oDmaData), 32'(exp_dma));

    // Reset asserted in the middle of ACCESS of a write
    iCpuReq = 1'b1; iCpuWe = 1'b1; iCpuAddr = 18'h2AAAA; iCpuData = 16'h5A5A;
    tick;
    iCpuReq = 1'b0;
    tick;
    chk("rst_pre_we_low", 32'(oSramWe_n), 0);
    Reset = 1'b1;
    tick;
    chk("rst_mid_strobes", 32'(strobes()), 32'(IDLE_STROBES));
    chk("rst_mid_addr", 32'(oSramAddr), 0);
    chk("rst_mid_cpu_data", 32'(oCpuData), 0);
    Reset = 1'b0;
    exp_cpu = '0; exp_dma = '0; last_dma = 1'b0;
    n_acks_rst = 0;
    for (int i = 0; i < W + 3; i++) begin
      tick;
      if (oCpuAck || oDmaAck || oBusy) n_acks_rst++;
    end
    chk("rst_no_ack", n_acks_rst, 0);

    // Recovery transaction after the abort
    txn(1'b0, 1'b0, 18'h00123, 16'h0, got);
    chk("post_reset_read", 32'(got), 32'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, SRAM data width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, access-strobe length in clocks; legal range 1..15.
REQ-004 SHALL have port Clock  in  1  sole clock, rising edge.
REQ-005 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports iCpuReq in 1, iCpuWe in 1, iCpuAddr in ADDR_W, iCpuData in DATA_W  CPU request: 1 = write, 0 = read.
REQ-007 SHALL have ports oCpuData out DATA_W, oCpuAck out 1  CPU read data and completion pulse.
REQ-008 SHALL have ports iDmaReq in 1, iDmaAddr in ADDR_W, oDmaData out DATA_W, oDmaAck out 1  read-only second requester (display/LED scan).
REQ-009 SHALL have ports oSramAddr out ADDR_W, oSramData out DATA_W, iSramData in DATA_W, oSramDataOe out 1  SRAM address and data; oSramDataOe drives the pad tristate enable.
REQ-010 SHALL have ports oSramCe_n, oSramOe_n, oSramWe_n out 1 each  active-low SRAM strobes; oBusy out 1 high when the FSM is not in IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, SETUP, ACCESS, DONE; transitions IDLE->SETUP on grant, SETUP->ACCESS, ACCESS->DONE after WAIT_CYCLES cycles, DONE->IDLE.
REQ-012 SHALL, in IDLE with any request, latch the granted requester's address, write data, write flag and a grant id at the same edge.
REQ-013 SHALL, in SETUP, drive Ce_n=0; for a read also drive Oe_n=0; for a write also drive oSramDataOe=1; We_n stays 1.
REQ-014 SHALL, in ACCESS, hold the SETUP strobes and additionally drive We_n=0 for writes; a down-counter loaded with WAIT_CYCLES-1 on entry leaves ACCESS when it reaches 0.
REQ-015 SHALL capture iSramData into the granted requester's data register on the ACCESS->DONE edge (reads only); the other requester's data register is unchanged.
REQ-016 SHALL, in DONE, drive We_n=1 and Oe_n=1 while keeping Ce_n=0, oSramDataOe and oSramAddr at their ACCESS values (write hold time), and pulse the granted requester's Ack for exactly one cycle.
REQ-017 SHALL give a latency from the request-sampling edge to the Ack cycle of WAIT_CYCLES+2 clocks; back-to-back transactions are separated by one IDLE cycle.
REQ-018 SHALL treat the request as sampled only in IDLE; a request that deasserts mid-transaction still completes and acks; a request still high in the IDLE cycle after its Ack is a new transaction.
REQ-019 SHALL keep oSramAddr, oSramData, oCpuData and oDmaData stable outside transactions (last value held).
REQ-020 SHALL never assert oCpuAck and oDmaAck in the same cycle.

Reset
REQ-021 SHALL, on Reset sampled high, enter IDLE and set Ce_n=Oe_n=We_n=1, oSramDataOe=0, oCpuAck=oDmaAck=0, oBusy=0, oSramAddr=0, oSramData=0, oCpuData=0, oDmaData=0, counter=0 and the round-robin pointer to "CPU last".
REQ-022 SHALL, on reset during any state, abort the transaction without issuing an Ack; Reset has priority over all other events.

Configuration
REQ-023 SHALL honour macro SRAM_ARB_ROUND_ROBIN_EN: when defined, on simultaneous requests grant the requester not granted last (pointer updated on each grant); when undefined, the CPU always wins and the pointer logic is absent.
REQ-024 SHALL grant the sole requester immediately in both configurations.

Verification (WAIT_CYCLES=2)
REQ-025 SHALL cover a CPU write of addr 0x00123, data 0xBEEF: We_n low for exactly 2 cycles, DataOe high SETUP..DONE, oCpuAck pulses on the 4th cycle after sampling.
REQ-026 SHALL cover a CPU read of 0x00123 with iSramData=0xBEEF: oCpuData=0xBEEF in the Ack cycle; We_n never asserted.
REQ-027 SHALL cover CPU and DMA requesting together, held high continuously: with the macro, grants alternate CPU, DMA, CPU; without it, the CPU is granted each time and DMA is starved.
REQ-028 SHALL cover Reset asserted during ACCESS: the next cycle shows all strobes high, DataOe=0, and no Ack.
REQ-029 SHALL cover iCpuReq dropped after 1 cycle: the transaction completes, oCpuAck pulses once, and the FSM returns to IDLE with oBusy=0.
